// File: rtl/ui_pkg.sv
// Shared UI definitions for the front-panel button event logic:
// FSM state encoding and the default hold/repeat timings.
package ui_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE    = 2'd0;
  localparam state_t PRESSED = 2'd1;
  localparam state_t REPEAT  = 2'd2;

  // Every button on the panel uses these timings.
  localparam int unsigned CLK_HZ         = 24_000_000;
  localparam int unsigned LONG_DEFAULT   = CLK_HZ / 2;
  localparam int unsigned REPEAT_DEFAULT = CLK_HZ / 8;

  function automatic int unsigned max_u(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Saturating hold counter; done is a combinational compare to terminal.
// Ports: clk, reset, clear, terminal (compare value), done.
module hold_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic [W-1:0] terminal,
  output logic         done
);

  logic [W-1:0] count;

  assign done = (count == terminal);

  // Holds at terminal instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (!done) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/button_events.sv
// Turns the debounced button level into press/release/long/step pulses.
// Ports: clk, reset, debounced in; press, released, long_press, step, held out.
import ui_pkg::*;

module button_events #(
  parameter int unsigned LONG_CYCLES   = LONG_DEFAULT,
  parameter int unsigned REPEAT_CYCLES = REPEAT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic debounced,
  output logic press,
  output logic released,
  output logic long_press,
  output logic step,
  output logic held
);

  localparam int unsigned TW =
    $clog2(max_u(LONG_CYCLES, REPEAT_CYCLES));
  localparam logic [TW-1:0] LONG_T = TW'(LONG_CYCLES - 1);
  localparam logic [TW-1:0] REP_T  = TW'(REPEAT_CYCLES - 1);

  state_t        state;
  state_t        state_d;
  logic          prev;
  logic          rise;
  logic          fall;
  logic          active;
  logic          clear;
  logic          done;
  logic [TW-1:0] terminal;
  logic          press_d;
  logic          rel_d;
  logic          long_d;
  logic          step_d;

  assign rise   = debounced & ~prev;
  assign fall   = ~debounced & prev;
  assign active = (state == PRESSED) || (state == REPEAT);

  hold_timer #(
    .W(TW)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .terminal(terminal),
    .done    (done)
  );

  // prev resets high so a button held through reset needs a fresh press.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      prev       <= 1'b1;
      press      <= 1'b0;
      released   <= 1'b0;
      long_press <= 1'b0;
      step       <= 1'b0;
      held       <= 1'b0;
    end else begin
      state      <= state_d;
      prev       <= debounced;
      press      <= press_d;
      released   <= rel_d;
      long_press <= long_d;
      step       <= step_d;
      held       <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (rise) state_d = PRESSED;
      end
      PRESSED: begin
        if (fall)      state_d = IDLE;
        else if (done) state_d = REPEAT;
      end
      REPEAT: begin
        if (fall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A fall masks any terminal-count event in the same cycle.
  always_comb begin
    press_d  = (state == IDLE) && rise;
    rel_d    = active && fall;
    long_d   = (state == PRESSED) && !fall && done;
    step_d   = press_d || long_d
            || ((state == REPEAT) && !fall && done);
    clear    = (state == IDLE) || (active && !fall && done);
    terminal = (state == REPEAT) ? REP_T : LONG_T;
  end

endmodule

// File: tb/tb_button_events.sv
// Self-checking bench for button_events with LONG=10, REPEAT=4.
// Table vectors, directed corner cases and random runs vs. a model.
module tb_button_events;

  localparam int L = 10;
  localparam int R = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic debounced = 1'b0;
  logic press, released, long_press, step, held;
  logic [4:0] act;

  always #5 clk = ~clk;

  assign act = {press, released, long_press, step, held};

  button_events #(
    .LONG_CYCLES  (L),
    .REPEAT_CYCLES(R)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .debounced (debounced),
    .press     (press),
    .released  (released),
    .long_press(long_press),
    .step      (step),
    .held      (held)
  );

  int checks = 0;
  int errors = 0;

  // Reference: age = cycles since the press pulse while held.
  bit         m_prev = 1'b1;
  bit         m_active = 1'b0;
  int         m_age = 0;
  logic [4:0] exp_o = '0;

  int n_press, n_rel, n_long, n_step, n_held;
  int cyc, press_cyc, rel_cyc;
  int step_ages[$];

  typedef struct {
    bit         r;
    bit         d;
    logic [4:0] e;
  } vec_t;

  vec_t tbl[5];
  int   want_steps[7] = '{0, 10, 14, 18, 22, 26, 30};

  task automatic check(input string name,
                       input logic [31:0] a,
                       input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, a, e);
    end
  endtask

  task automatic model(input bit r, input bit d);
    bit rise, fall;
    exp_o = '0;
    if (r) begin
      m_prev   = 1'b1;
      m_active = 1'b0;
      m_age    = 0;
    end else begin
      rise   = d && !m_prev;
      fall   = !d && m_prev;
      m_prev = d;
      if (!m_active) begin
        if (rise) begin
          m_active = 1'b1;
          m_age    = 0;
          exp_o    = 5'b10011;
        end
      end else if (fall) begin
        m_active = 1'b0;
        exp_o    = 5'b01000;
      end else begin
        m_age++;
        exp_o[0] = 1'b1;
        if (m_age == L)
          exp_o[2:1] = 2'b11;
        else if (m_age > L && (m_age - L) % R == 0)
          exp_o[1] = 1'b1;
      end
    end
  endtask

  task automatic clr();
    n_press = 0; n_rel = 0; n_long = 0;
    n_step = 0; n_held = 0; cyc = 0;
    press_cyc = -1; rel_cyc = -1;
    step_ages.delete();
  endtask

  task automatic tick(input bit r, input bit d);
    @(negedge clk);
    reset = r;
    debounced = d;
    @(posedge clk);
    model(r, d);
    #1;
    check("cycle_outputs", 32'(act), 32'(exp_o));
    n_press += int'(press);
    n_rel   += int'(released);
    n_long  += int'(long_press);
    n_step  += int'(step);
    n_held  += int'(held);
    if (press && press_cyc < 0) press_cyc = cyc;
    if (released && rel_cyc < 0) rel_cyc = cyc;
    if (step) step_ages.push_back(cyc);
    cyc++;
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b1, 5'b10011};
    tbl[1] = '{1'b0, 1'b0, 5'b01000};
    tbl[2] = '{1'b0, 1'b1, 5'b10011};
    tbl[3] = '{1'b0, 1'b0, 5'b01000};
    tbl[4] = '{1'b0, 1'b0, 5'b00000};

    // Reset start state and quiet idle.
    clr();
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    check("reset_outputs", 32'(act), 32'd0);
    clr();
    for (int i = 0; i < 50; i++) tick(1'b0, 1'b0);
    check("idle_activity",
          n_press + n_rel + n_long + n_step + n_held, 0);

    // Short press.
    clr();
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    check("short_press_cnt", n_press, 1);
    check("short_press_cyc", press_cyc, 0);
    check("short_rel_cyc", rel_cyc, 5);
    check("short_long_cnt", n_long, 0);
    check("short_step_cnt", n_step, 1);

    // Long hold with auto-repeat.
    clr();
    for (int i = 0; i < 31; i++) tick(1'b0, 1'b1);
    for (int i = 0; i < 2; i++) tick(1'b0, 1'b0);
    check("long_step_cnt", step_ages.size(), 7);
    for (int i = 0; i < 7; i++)
      if (i < step_ages.size())
        check("long_step_at", step_ages[i], want_steps[i]);
    check("long_long_cnt", n_long, 1);
    check("long_rel_cyc", rel_cyc, 31);

    // Fall coincides with terminal count.
    clr();
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    check("bound_long_cnt", n_long, 0);
    check("bound_step_cnt", n_step, 1);
    check("bound_rel_cnt", n_rel, 1);

    // Reset while held.
    clr();
    for (int i = 0; i < 13; i++) tick(1'b0, 1'b1);
    for (int i = 0; i < 2; i++) tick(1'b1, 1'b1);
    check("rst_held_outputs", 32'(act), 32'd0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);
    check("rst_held_press", n_press, 1);
    check("rst_held_rel", n_rel, 0);
    tick(1'b0, 1'b0);
    check("rst_fall_ignored", 32'(released), 32'd0);
    tick(1'b0, 1'b1);
    check("rst_repress", 32'({press, held}), 32'd3);
    for (int i = 0; i < 2; i++) tick(1'b0, 1'b0);

    // Fast toggle table.
    for (int i = 0; i < 5; i++) begin
      tick(tbl[i].r, tbl[i].d);
      check("toggle_vec", 32'(act), 32'(tbl[i].e));
    end

    // Random level runs with occasional reset.
    for (int i = 0; i < 150; i++) begin
      bit lvl;
      bit rs;
      int n;
      lvl = 1'($urandom_range(0, 1));
      rs  = ($urandom_range(0, 19) == 0);
      n   = $urandom_range(1, 25);
      for (int j = 0; j < n; j++) tick(rs && j == 0, lvl);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/button_events.md
# button_events

Converts the level-stable output of the debouncer into single-cycle UI events for the scope controls: press, release, long-press, and auto-repeat step pulses. It sits directly downstream of the button debouncer and upstream of the control registers (timebase, trigger level, offset), which increment once per `step` pulse. One instance per front-panel button.

## Interface
- `LONG_CYCLES`, default 12_000_000: clocks a press must be held before `long_press` fires. Must be ≥ 2.
- `REPEAT_CYCLES`, default 3_000_000: clocks between auto-repeat `step` pulses after `long_press`. Must be ≥ 1.
- `clk` in 1: system clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `debounced` in 1: stable button level from the debouncer, synchronous to `clk`.
- `press` out 1: one-cycle pulse on an accepted rising edge.
- `release` out 1: one-cycle pulse on a falling edge after an accepted press.
- `long_press` out 1: one-cycle pulse when the hold reaches `LONG_CYCLES`.
- `step` out 1: one-cycle pulse on press, on long_press, and on every repeat tick.
- `held` out 1: high while state is PRESSED or REPEAT.

## Operation
- Edge detect uses a `prev` register holding the last sampled `debounced`.
  - rise = `debounced & ~prev`
  - fall = `~debounced & prev`
- FSM states: IDLE, PRESSED, REPEAT.
- IDLE:
  - On rise: go to PRESSED, clear timer to 0, pulse `press` and `step`.
  - Otherwise stay in IDLE.
- PRESSED:
  - On fall: go to IDLE, pulse `release`.
  - Otherwise, if timer == `LONG_CYCLES-1`: go to REPEAT, clear timer, pulse `long_press` and `step`.
  - Otherwise increment timer.
- REPEAT:
  - On fall: go to IDLE, pulse `release`.
  - Otherwise, if timer == `REPEAT_CYCLES-1`: clear timer, pulse `step`.
  - Otherwise increment timer.
- Release has priority. If fall occurs in the same cycle the timer reaches its terminal value, only `release` pulses; there is no `long_press` or `step`.
- Timer width is `$clog2(max(LONG_CYCLES, REPEAT_CYCLES))`. The timer never exceeds its terminal value and never wraps.
- Reset values:
  - State is IDLE and timer is 0.
  - `prev` is 1, so a button held through reset produces no `press`. It must be released and pressed again.
  - All outputs are 0.
- Reset asserted mid-hold aborts with no `release` pulse.
- `release` fires only from PRESSED or REPEAT. A fall seen in IDLE (for example after reset) is ignored.
- `press`, `long_press` and `step` are mutually consistent. `step` is high in every cycle where `press` or `long_press` is high. `press` and `long_press` are never high together.

## Timing
- All outputs are registered.
- Rise sampled at cycle N gives `press`/`step` high in cycle N+1.
- Fall sampled at cycle M gives `release` high in M+1; `held` is low from M+1.
- With `press` at cycle P and the button still held:
  - `long_press` fires at P+`LONG_CYCLES`.
  - Repeat `step` pulses then fire at P+`LONG_CYCLES`+k·`REPEAT_CYCLES`, for k ≥ 1.
- `held` goes high in the same cycle as `press`.
- There is no minimum gap between events. Back-to-back rise, fall, rise on consecutive cycles is legal and produces press, release, press.

## Structure
- Shared package/header `ui_pkg` holds:
  - state encoding localparams (IDLE=0, PRESSED=1, REPEAT=2);
  - the default `LONG_CYCLES`/`REPEAT_CYCLES` values derived from the system clock frequency, so that all buttons share them.
- One natural sub-module: `hold_timer`.
  - Ports: `clk`, `reset`, `clear`, `terminal` (value), `done` (combinational compare).
  - The FSM drives `clear` and selects `terminal` per state.
- The top level holds the `prev` register, the FSM, and the output registers.

## Test plan
All scenarios use `LONG_CYCLES`=10 and `REPEAT_CYCLES`=4.
- **Short press:** `debounced` high for 5 cycles, then low → exactly one `press`/`step` 1 cycle after the rise, one `release` 1 cycle after the fall, no `long_press`.
- **Long hold:** hold for 30 cycles → `press` at P, `long_press`+`step` at P+10, `step` at P+14, P+18, P+22, P+26, P+30 while held, then `release` after the fall.
- **Boundary:** fall sampled so that it coincides with timer==9 → `release` only, with zero `long_press` and zero extra `step`.
- **Reset while held:** assert `reset` at P+12 with the button still high, then deassert → all outputs 0 and no `press` until the button goes low then high again, which yields `press` 1 cycle after the new rise.
- **Fast toggle:** `debounced` pattern 1,0,1,0 on consecutive cycles → `press`, `release`, `press`, `release` on consecutive cycles, each one cycle late, with `held` tracking.
- **Reset start state:** reset released with the button low, then a fall-free idle period of 50 cycles → no outputs ever asserted.
